// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes and requester IDs shared by alu_arbiter and alu
package alu_arbiter_pkg;
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_XOR   = 2'b01;
  localparam logic [1:0] ALU_OP_PASSB = 2'b10;
  localparam logic [1:0] ALU_OP_SUB   = 2'b11;
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;
endpackage

// File: rtl/alu.sv
// alu: combinational add/xor/pass-b/subtract with zero flag, modulo 2^WIDTH
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  always_comb begin
    result = op == ALU_OP_ADD ? a + b :
             op == ALU_OP_XOR ? a ^ b :
             op == ALU_OP_PASSB ? b : a - b;
    zero = result == '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two valid/ready requesters with a one-entry response slot.
// ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);
  logic             slot_free, grant, accept, zero;
  logic [WIDTH-1:0] a, b, result;
  logic [1:0]       op;
  logic             rsp_valid_d, rsp_valid_q, rsp_id_d, rsp_id_q, rsp_zero_d, rsp_zero_q;
  logic [WIDTH-1:0] rsp_result_d, rsp_result_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic prio_d, prio_q;
  always_comb begin
    grant  = req1_valid && (!req0_valid || prio_q == REQ_ID1);
    prio_d = accept ? ~grant : prio_q;
  end
  always_ff @(posedge clk)
    prio_q <= rst ? REQ_ID0 : prio_d;
`else
  always_comb grant = req1_valid && !req0_valid;
`endif
  always_comb begin
    slot_free  = !rsp_valid_q || rsp_ready;
    req0_ready = slot_free && grant == REQ_ID0 && req0_valid && !rst;
    req1_ready = slot_free && grant == REQ_ID1 && req1_valid && !rst;
    accept     = req0_ready || req1_ready;
    a  = grant ? req1_a : req0_a;
    b  = grant ? req1_b : req0_b;
    op = grant ? req1_op : req0_op;
    rsp_valid_d  = accept || (rsp_valid_q && !rsp_ready);
    rsp_id_d     = accept ? grant : rsp_id_q;
    rsp_result_d = accept ? result : rsp_result_q;
    rsp_zero_d   = accept ? zero : rsp_zero_q;
  end
  alu #(.WIDTH(WIDTH)) u_alu (
    .a(a), .b(b), .op(op), .result(result), .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= REQ_ID0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [1:0]  req0_op = 0, req1_op = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_id, rsp_zero;
  logic [15:0] rsp_result;
  int checks = 0, errors = 0;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  // Requester protocol monitor: a pending request must stay valid with stable payload
  logic        pend0 = 0, pend1 = 0;
  logic [33:0] pay0, pay1;
  always @(posedge clk) begin
    if (!rst && pend0) begin
      checks++;
      if (!req0_valid || {req0_a, req0_b, req0_op} !== pay0) begin
        errors++;
        $display("FAIL req0_hold: valid=%b payload=%h required valid=1 payload=%h", req0_valid, {req0_a, req0_b, req0_op}, pay0);
      end
    end
    if (!rst && pend1) begin
      checks++;
      if (!req1_valid || {req1_a, req1_b, req1_op} !== pay1) begin
        errors++;
        $display("FAIL req1_hold: valid=%b payload=%h required valid=1 payload=%h", req1_valid, {req1_a, req1_b, req1_op}, pay1);
      end
    end
    pend0 <= !rst && req0_valid && !req0_ready;
    pend1 <= !rst && req1_valid && !req1_ready;
    pay0  <= {req0_a, req0_b, req0_op};
    pay1  <= {req1_a, req1_b, req1_op};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req1_valid = 1; rsp_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    tick(); tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== 19'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%b r=%h z=%b required all 0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    req0_valid = 0; req1_valid = 0; rst = 0;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0004; req0_op = 2'b00; rsp_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b required 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b0, 16'h0007, 1'b0}) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%b r=%h z=%b required v=1 id=0 r=0007 z=0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_opcodes();
    logic [15:0] exp [4] = '{16'h100E, 16'h0FF0, 16'h0F0F, 16'hF1F0};
    rsp_ready = 1; req1_a = 16'h00FF; req1_b = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1; req1_op = 2'(i);
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
        errors++; $display("FAIL op%0d_ready: got %b required 1", i, req1_ready);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, exp[i]}) begin
        errors++; $display("FAIL op%0d_rsp: got v=%b id=%b r=%h required v=1 id=1 r=%h", i, rsp_valid, rsp_id, rsp_result, exp[i]);
      end
    end
    req1_valid = 0;
    tick();
  endtask

  task automatic test_zero_wrap();
    logic [15:0] ta [3] = '{16'h1234, 16'h0000, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h1234, 16'h0001, 16'h0001};
    logic [1:0]  to [3] = '{2'b11, 2'b11, 2'b00};
    logic [15:0] er [3] = '{16'h0000, 16'hFFFF, 16'h0000};
    logic        ez [3] = '{1'b1, 1'b0, 1'b1};
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_a = ta[i]; req0_b = tb[i]; req0_op = to[i];
      tick();
      checks++;
      if ({rsp_valid, rsp_result, rsp_zero} !== {1'b1, er[i], ez[i]}) begin
        errors++; $display("FAIL zero_wrap%0d: got v=%b r=%h z=%b required v=1 r=%h z=%b", i, rsp_valid, rsp_result, rsp_zero, er[i], ez[i]);
      end
    end
    req0_valid = 0;
    tick();
  endtask

  task automatic test_contention();
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic ids [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic ids [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1; tick(); rst = 0;
    rsp_ready = 1;
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0002; req0_op = 2'b00;
    req1_valid = 1; req1_a = 16'h0010; req1_b = 16'h0020; req1_op = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({rsp_valid, rsp_id} !== {1'b1, ids[i]}) begin
        errors++; $display("FAIL contention%0d: got v=%b id=%b required v=1 id=%b", i, rsp_valid, rsp_id, ids[i]);
      end
    end
`ifdef ALU_ARB_ROUND_ROBIN_EN
    req1_valid = 0;
    tick();
    checks++;
    if ({rsp_id, rsp_result} !== {1'b0, 16'h0003}) begin
      errors++; $display("FAIL contention_tail: got id=%b r=%h required id=0 r=0003", rsp_id, rsp_result);
    end
    req0_valid = 0;
`else
    req0_valid = 0;
    tick();
    checks++;
    if ({rsp_id, rsp_result} !== {1'b1, 16'h0030}) begin
      errors++; $display("FAIL contention_tail: got id=%b r=%h required id=1 r=0030", rsp_id, rsp_result);
    end
    req1_valid = 0;
`endif
    tick();
  endtask

  task automatic test_back_pressure();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 2'b00;
    tick();
    req0_a = 16'h0005; req0_b = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero} !== {4'b0010, 16'h0002, 1'b0}) begin
        errors++; $display("FAIL bp%0d: got rdy=%b%b v=%b id=%b r=%h z=%b required rdy=00 v=1 id=0 r=0002 z=0", i, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero);
      end
      tick();
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b required 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 16'h000A}) begin
      errors++; $display("FAIL bp_release_rsp: got v=%b id=%b r=%h required v=1 id=0 r=000a", rsp_valid, rsp_id, rsp_result);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 16'h0002; req0_b = 16'h0002; req0_op = 2'b00;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 16'h0000; req1_b = 16'h0055; req1_op = 2'b10;
    rst = 1;
    #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
      errors++; $display("FAIL midrst_during: got v=%b rdy=%b%b required v=1 rdy=00", rsp_valid, req0_ready, req1_ready);
    end
    tick();
    rst = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== 19'h0) begin
      errors++; $display("FAIL midrst_after: got v=%b id=%b r=%h z=%b required all 0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b required 1", req1_ready);
    end
    tick();
    req1_valid = 0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b1, 16'h0055, 1'b0}) begin
      errors++; $display("FAIL midrst_rsp: got v=%b id=%b r=%h z=%b required v=1 id=1 r=0055 z=0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_zero_wrap();
    test_contention();
    test_back_pressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
